mult32_seq: RTL and testbench
=============================

Name: mult32_seq

Overview:
- Multi-cycle unsigned 32x32 -> 64-bit shift-and-add multiplier.
- Sits directly downstream of adder32 in the execute stage: each iteration consumes adder32's sum and carry.
- Serves MIPS MULTU and feeds the HI/LO registers.
- One partial-product add per clock, so no second carry chain is needed.

Parameters:
- WIDTH, 32: operand width. Fixed at 32 because the datapath must instantiate adder32; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE or DONE
- a  input  32  multiplicand; captured on the accepting edge
- b  input  32  multiplier; captured on the accepting edge
- busy  output  1  high while an iteration sequence is running
- done  output  1  one-cycle pulse: product valid and newly updated
- product  output  64  result register; holds until the next completion

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, product=0, internal M/P/count=0.
- Release of reset is synchronous to the next clk edge.
- Internal registers:
  - M[31:0]: multiplicand.
  - P[63:0]: accumulator, high half P[63:32], low half P[31:0].
  - count[5:0]: iteration counter.
- FSM states: IDLE, RUN, DONE.
- Accept: in IDLE or DONE with start=1 at edge E:
  - M<=a, P<={32'b0, b}, count<=0, state<=RUN.
- start=1 while in RUN is ignored; operands are not re-captured.
- RUN, each edge:
  - adder32 is instantiated with a=P[63:32], b=(P[0] ? M : 0), cin=0.
  - Update: P <= {carry, sum, P[31:1]}.
  - The adder carry-out is the new bit 63; no carry is lost.
  - count <= count+1.
- RUN exit: at the edge where count==31 (the 32nd iteration):
  - product <= the new P value, state <= DONE.
- DONE: lasts exactly one cycle.
  - Goes to RUN if start=1, else IDLE.
  - done=1 only in DONE.
- Decode: busy = (state==RUN); done = (state==DONE); both registered-state decodes, glitch-free.
- Latency: start sampled at edge E.
  - busy is high for the 32 cycles after E.
  - product updates and done rises after edge E+32.
  - Back-to-back throughput is one result per 33 cycles.
- Simultaneous events:
  - start in the DONE cycle: done still pulses, and the new operands load on that edge.
  - product keeps the old result until the new run completes.
- Reset mid-RUN: immediate abort; no done pulse; product cleared to 0.
- Arithmetic edge cases (no special casing; the algorithm covers them):
  - a=0 or b=0 gives product=0.
  - a=b=0xFFFFFFFF must not overflow 64 bits.
- X-safety: a/b are don't-care outside the accepting edge.

Test Plan:
- Basic: reset, start with a=3, b=5 -> busy for 32 cycles; done one cycle after edge E+32; product=64'h0000_0000_0000_000F.
- Max operands: a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001, which exercises carry-out into bit 63 each iteration.
- Zero/identity, checked against a golden model:
  - a=0, b=32'h12345678 -> product=0.
  - a=32'h30E0E0E0, b=1 -> product=64'h00000000_30E0E0E0.
- Ignore while busy: start a=7, b=6; at cycle 10 pulse start with a=9, b=9 -> product=42 at done; no extra done.
- Back-to-back: hold start=1 through the DONE cycle with a=2, b=32'h80000000:
  - first product remains until the second done;
  - second product=64'h00000001_00000000 exactly 33 cycles after the first done.
- Reset mid-op: start a=b=32'hFFFF, drop rst_n at cycle 15 -> busy=0, done=0, product=0 immediately.
  - After release, a fresh start a=4, b=4 -> product=16.

Source files
------------

// File: rtl/mult32_seq.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier (MIPS MULTU).
// Ports: clk, rst_n, start, a, b in; busy, done, product out.

module adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, cin_i};
endmodule

module mult32_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;

  // Multiplier LSB selects whether M joins the high half this step.
  assign addend = p_q[0] ? m_q : '0;

  adder32 u_add (
    .a_i    (p_q[2*WIDTH-1:WIDTH]),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (carry)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d     = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Carry-out becomes the new MSB, so no bit is lost.
        p_d   = {carry, sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH-1)) begin
          prod_d  = p_d;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Directed-vector bench for mult32_seq.
// Checks latency, result, busy/done and reset abort.

module tb_mult32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_checks;
  int n_fail;

  mult32_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive operands with start; returns #1 after accepting edge E.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hx;
    b     = 32'hx;
  endtask

  // Called #1 after E; checks the full 32-cycle busy window.
  task automatic finish_op(input string tag,
                           input logic [63:0] old_p,
                           input logic [63:0] exp);
    check({tag, "_busy0"}, {63'b0, busy}, 64'd1);
    repeat (31) @(posedge clk);
    #1;
    check({tag, "_busy31"}, {62'b0, busy, done}, 64'd2);
    check({tag, "_hold"}, product, old_p);
    @(posedge clk);
    #1;
    check({tag, "_done"}, {62'b0, busy, done}, 64'd1);
    check({tag, "_prod"}, product, exp);
    @(posedge clk);
    #1;
    check({tag, "_after"}, {62'b0, busy, done}, 64'd0);
    check({tag, "_keep"}, product, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    #12;
    check("rst_flags", {62'b0, busy, done}, 64'd0);
    check("rst_prod", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_flags", {62'b0, busy, done}, 64'd0);

    launch(32'd3, 32'd5);
    finish_op("basic", 64'd0, 64'h0000_0000_0000_000F);

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("max", 64'hF, 64'hFFFF_FFFE_0000_0001);

    launch(32'd0, 32'h1234_5678);
    finish_op("zero_a", 64'hFFFF_FFFE_0000_0001, 64'd0);

    launch(32'h30E0_E0E0, 32'd1);
    finish_op("ident", 64'd0, 64'h0000_0000_30E0_E0E0);

    launch(32'hDEAD_BEEF, 32'd0);
    finish_op("zero_b", 64'h0000_0000_30E0_E0E0, 64'd0);

    // Start pulse mid-run must be ignored.
    launch(32'd7, 32'd6);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_busy", {63'b0, busy}, 64'd1);
    repeat (21) @(posedge clk);
    #1;
    check("ign_busy31", {62'b0, busy, done}, 64'd2);
    @(posedge clk);
    #1;
    check("ign_done", {62'b0, busy, done}, 64'd1);
    check("ign_prod", product, 64'd42);
    @(posedge clk);
    #1;
    check("ign_nodone", {62'b0, busy, done}, 64'd0);

    // Back-to-back: start held, new operands loaded in DONE cycle.
    @(negedge clk);
    start = 1'b1;
    a     = 32'd5;
    b     = 32'h0000_1000;
    @(posedge clk);
    #1;
    repeat (31) @(posedge clk);
    #1;
    a = 32'd2;
    b = 32'h8000_0000;
    @(posedge clk);
    #1;
    check("b2b_done1", {62'b0, busy, done}, 64'd1);
    check("b2b_prod1", product, 64'h5000);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'hx;
    b     = 32'hx;
    check("b2b_rerun", {62'b0, busy, done}, 64'd2);
    repeat (31) @(posedge clk);
    #1;
    check("b2b_hold", product, 64'h5000);
    check("b2b_wait", {63'b0, done}, 64'd0);
    @(posedge clk);
    #1;
    check("b2b_done2", {63'b0, done}, 64'd1);
    check("b2b_prod2", product, 64'h0000_0001_0000_0000);

    // Reset mid-run aborts immediately.
    @(posedge clk);
    launch(32'h0000_FFFF, 32'h0000_FFFF);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_flags", {62'b0, busy, done}, 64'd0);
    check("mid_prod", product, 64'd0);
    @(posedge clk);
    #1;
    check("mid_nodone", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_idle", {62'b0, busy, done}, 64'd0);

    launch(32'd4, 32'd4);
    finish_op("fresh", 64'd0, 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
